sprite_animator: RTL and testbench

//  Parametrised animated-sprite renderer, the generalised successor of the

---
 rtl/sprite_animator.sv | 139 +++++++++++++
 tb/tb_sprite_animator.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_animator.sv
// Animated sprite renderer: box test, frame-ROM addressing, multi-action frame
// sequencing and ROM-latency alignment, with tear-free position latching.
module sprite_animator #(
   parameter int              SPR_W     = 31,
   parameter int              SPR_H     = 23,
   parameter int              N_ACT     = 4,
   parameter int              N_FRM     = 4,
   parameter int              ROM_LAT   = 1,
   parameter int              ADDR_W    = 14,
   parameter logic [11:0]     KEY_RGB   = 12'hFFF,
   parameter logic [N_ACT-1:0] LOOP_MASK = '1,
   localparam int             ACT_W     = (N_ACT > 1) ? $clog2(N_ACT) : 1,
   localparam int             FRM_W     = (N_FRM > 1) ? $clog2(N_FRM) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              frame_tick,
   input  logic [9:0]        col,
   input  logic [9:0]        row,
   input  logic [9:0]        pos_x,
   input  logic [9:0]        pos_y,
   input  logic              dir,
   input  logic [ACT_W-1:0]  action,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [11:0]       rom_data,
   output logic              is_sprite,
   output logic [11:0]       sprite_rgb,
   output logic              anim_done
);

   localparam logic [9:0]       W_LIM    = 10'(SPR_W);
   localparam logic [9:0]       H_LIM    = 10'(SPR_H);
   localparam logic [9:0]       W_LAST   = 10'(SPR_W - 1);
   localparam logic [FRM_W-1:0] LAST_FRM = FRM_W'(N_FRM - 1);

   logic             frame_start;
   logic [ACT_W-1:0] action_ok;
   logic [ACT_W-1:0] eff_act;

   // Shadow copies of the object state, refreshed only at frame start.
   logic             sh_valid;
   logic [9:0]       sh_x;
   logic [9:0]       sh_y;
   logic             sh_dir;
   logic [ACT_W-1:0] sh_act;

   logic [FRM_W-1:0] frame;
   logic [FRM_W-1:0] frame_inc;
   logic [ACT_W-1:0] prev_act;

   logic [9:0]       dx;
   logic [9:0]       dy;
   logic [9:0]       ax;
   logic             in_box;
   logic [31:0]      addr_full;

   logic               box_s0;
   logic [ROM_LAT-1:0] box_pipe;
   logic               box_d;

   assign frame_start = (col == 10'd0) && (row == 10'd0);
   assign action_ok   = (32'(action) < 32'(N_ACT)) ? action : '0;
   // A tick landing on the latch cycle must see the action being latched now.
   assign eff_act     = frame_start ? action_ok : sh_act;
   assign frame_inc   = frame + FRM_W'(1);
   assign box_d       = box_pipe[ROM_LAT-1];

   // NOTE: all state below uses non-blocking assignments so every register
   // samples pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_valid <= 1'b0;
         sh_x     <= '0;
         sh_y     <= '0;
         sh_dir   <= 1'b1;
         sh_act   <= '0;
      end else if (frame_start) begin
         sh_valid <= 1'b1;
         sh_x     <= pos_x;
         sh_y     <= pos_y;
         sh_dir   <= dir;
         sh_act   <= action_ok;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame     <= '0;
         prev_act  <= '0;
         anim_done <= 1'b0;
      end else if (frame_tick) begin
         prev_act <= eff_act;
         if (eff_act != prev_act) begin
            frame     <= '0;
            anim_done <= 1'b0;
         end else if (frame == LAST_FRM) begin
            if (LOOP_MASK[eff_act]) frame <= '0;
            else                    anim_done <= 1'b1;
         end else begin
            frame <= frame_inc;
            if (!LOOP_MASK[eff_act] && (frame_inc == LAST_FRM)) anim_done <= 1'b1;
         end
      end
   end

   // Offsets wrap mod 1024, so pixels left of / above the box fail the compare.
   always_comb begin
      dx        = col - sh_x;
      dy        = row - sh_y;
      in_box    = sh_valid && (dx < W_LIM) && (dy < H_LIM);
      ax        = sh_dir ? dx : (W_LAST - dx);
      addr_full = 32'(ax) + 32'(dy) * 32'(SPR_W)
                + (32'(sh_act) * 32'(N_FRM) + 32'(frame)) * 32'(SPR_W * SPR_H);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rom_addr <= '0;
         box_s0   <= 1'b0;
         box_pipe <= '0;
      end else begin
         rom_addr    <= in_box ? addr_full[ADDR_W-1:0] : '0;
         box_s0      <= in_box;
         box_pipe[0] <= box_s0;
         for (int i = 1; i < ROM_LAT; i++) box_pipe[i] <= box_pipe[i-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sprite_rgb <= KEY_RGB;
         is_sprite  <= 1'b0;
      end else begin
         sprite_rgb <= box_d ? rom_data : KEY_RGB;
         is_sprite  <= box_d && (rom_data != KEY_RGB);
      end
   end

endmodule

// File: tb/tb_sprite_animator.sv
// Self-checking bench for sprite_animator: directed vectors, hand sequences
// for animation/latching/reset, and randomized traffic against a pixel model.
module tb_sprite_animator;

   localparam int          SPR_W     = 31;
   localparam int          SPR_H     = 23;
   localparam int          N_ACT     = 4;
   localparam int          N_FRM     = 4;
   localparam int          ADDR_W    = 14;
   localparam logic [11:0] KEY       = 12'hFFF;
   localparam logic [3:0]  LOOP_MASK = 4'b0111;
   localparam int          FRM_SZ    = SPR_W * SPR_H;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              frame_tick = 1'b0;
   logic [9:0]        col = '0;
   logic [9:0]        row = '0;
   logic [9:0]        pos_x = '0;
   logic [9:0]        pos_y = '0;
   logic              dir = 1'b1;
   logic [1:0]        action = '0;
   logic [ADDR_W-1:0] rom_addr;
   logic [11:0]       rom_data;
   logic              is_sprite;
   logic [11:0]       sprite_rgb;
   logic              anim_done;

   logic [11:0] rom_mem [0:(1<<ADDR_W)-1];

   sprite_animator #(
      .SPR_W(SPR_W), .SPR_H(SPR_H), .N_ACT(N_ACT), .N_FRM(N_FRM), .ROM_LAT(1),
      .ADDR_W(ADDR_W), .KEY_RGB(KEY), .LOOP_MASK(LOOP_MASK)
   ) dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick), .col(col), .row(row),
      .pos_x(pos_x), .pos_y(pos_y), .dir(dir), .action(action),
      .rom_addr(rom_addr), .rom_data(rom_data), .is_sprite(is_sprite),
      .sprite_rgb(sprite_rgb), .anim_done(anim_done)
   );

   always #5 clk = ~clk;

   // Synchronous ROM, one cycle of read latency.
   always @(posedge clk) rom_data <= rom_mem[rom_addr];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct { logic [11:0] rgb; logic is; } pix_t;
   pix_t pix_q[$];

   bit m_valid;
   int m_px, m_py, m_act, m_prev, m_n;
   bit m_dir;

   // Animation state is just "ticks since the action last changed".
   function automatic int cur_frame();
      if (LOOP_MASK[m_prev]) return m_n % N_FRM;
      return (m_n < N_FRM - 1) ? m_n : N_FRM - 1;
   endfunction

   function automatic bit cur_done();
      return !LOOP_MASK[m_prev] && (m_n >= N_FRM - 1);
   endfunction

   // Returns the ROM address for a pixel, or -1 when outside the sprite box.
   function automatic int model_addr(input int c, input int r);
      int dx, dy, ax;
      if (!m_valid) return -1;
      dx = (c - m_px) & 1023;
      dy = (r - m_py) & 1023;
      if (dx >= SPR_W || dy >= SPR_H) return -1;
      ax = m_dir ? dx : SPR_W - 1 - dx;
      return (ax + dy * SPR_W + (m_act * N_FRM + cur_frame()) * FRM_SZ) % (1 << ADDR_W);
   endfunction

   task automatic model_reset();
      pix_t k;
      m_valid = 0; m_px = 0; m_py = 0; m_dir = 1; m_act = 0; m_prev = 0; m_n = 0;
      k.rgb = KEY; k.is = 1'b0;
      pix_q.delete();
      pix_q.push_back(k);
      pix_q.push_back(k);
   endtask

   // One pixel clock: drive at negedge, model it, check at the next negedge.
   task automatic step(input bit tk, input int c, input int r, input int px,
                       input int py, input bit d, input int a);
      int   ea, na, eff;
      bit   ls;
      pix_t p;
      frame_tick = tk; col = 10'(c); row = 10'(r);
      pos_x = 10'(px); pos_y = 10'(py); dir = d; action = 2'(a);
      ea = model_addr(c, r);
      if (ea < 0) begin p.rgb = KEY; p.is = 1'b0; end
      else begin p.rgb = rom_mem[ea]; p.is = (rom_mem[ea] != KEY); end
      pix_q.push_back(p);
      na = (a < N_ACT) ? a : 0;
      ls = (c == 0) && (r == 0);
      if (tk) begin
         eff = ls ? na : m_act;
         if (eff != m_prev) m_n = 0;
         else if (m_n < 1000) m_n++;
         m_prev = eff;
      end
      if (ls) begin
         m_valid = 1; m_px = px & 1023; m_py = py & 1023; m_dir = d; m_act = na;
      end
      @(posedge clk);
      @(negedge clk);
      frame_tick = 1'b0;
      check("rom_addr", 32'(rom_addr), (ea < 0) ? 32'd0 : 32'(ea));
      p = pix_q.pop_front();
      check("sprite_rgb", 32'(sprite_rgb), 32'(p.rgb));
      check("is_sprite", 32'(is_sprite), 32'(p.is));
      check("anim_done", 32'(anim_done), 32'(cur_done()));
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      bit tick; int col; int row; int px; int py; bit dir; int act; int exp_addr;
   } vec_t;
   vec_t vecs [10];

   initial begin
      int frm_loop [5];
      int frm_shot [5];
      bit done_shot [5];
      int c, r, px, py;

      for (int i = 0; i < (1 << ADDR_W); i++)
         rom_mem[i] = ($urandom_range(0, 7) == 0) ? KEY : 12'($urandom);
      rom_mem[30]  = 12'h0F0;
      rom_mem[712] = KEY;

      vecs[0] = '{1'b0,   0,  0, 100, 50, 1'b1, 0,   0};
      vecs[1] = '{1'b0, 100, 50, 100, 50, 1'b1, 0,   0};
      vecs[2] = '{1'b0, 130, 72, 100, 50, 1'b1, 0, 712};
      vecs[3] = '{1'b0, 131, 72, 100, 50, 1'b1, 0,   0};
      vecs[4] = '{1'b0,   0,  0, 100, 50, 1'b0, 0,   0};
      vecs[5] = '{1'b0, 100, 50, 100, 50, 1'b0, 0,  30};
      vecs[6] = '{1'b0, 101, 51, 100, 50, 1'b0, 0,  60};
      vecs[7] = '{1'b0,  99, 50, 100, 50, 1'b0, 0,   0};
      vecs[8] = '{1'b0, 100, 49, 100, 50, 1'b0, 0,   0};
      vecs[9] = '{1'b0, 100, 72, 100, 50, 1'b0, 0, 712};

      frm_loop  = '{1, 2, 3, 0, 1};
      frm_shot  = '{0, 1, 2, 3, 3};
      done_shot = '{0, 0, 0, 1, 1};

      // Power-on reset.
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_addr", 32'(rom_addr), 32'd0);
      check("reset_rgb", 32'(sprite_rgb), 32'(KEY));
      check("reset_is_sprite", 32'(is_sprite), 32'd0);
      check("reset_anim_done", 32'(anim_done), 32'd0);
      rst = 1'b0;
      model_reset();

      // Box test and addressing, native and mirrored.
      for (int i = 0; i < 10; i++) begin
         step(vecs[i].tick, vecs[i].col, vecs[i].row, vecs[i].px, vecs[i].py,
              vecs[i].dir, vecs[i].act);
         check($sformatf("vec%0d_addr", i), 32'(rom_addr), 32'(vecs[i].exp_addr));
      end

      // Mirrored pixel 0F0 appears exactly three clocks after presentation;
      // the keyed pixel inside the box stays transparent.
      step(0, 100, 50, 100, 50, 0, 0);
      check("lat_clk1_is", 32'(is_sprite), 32'd0);
      step(0, 500, 300, 100, 50, 0, 0);
      check("key_in_box_rgb", 32'(sprite_rgb), 32'(KEY));
      check("key_in_box_is", 32'(is_sprite), 32'd0);
      step(0, 500, 300, 100, 50, 0, 0);
      check("lat_clk3_rgb", 32'(sprite_rgb), 32'h0F0);
      check("lat_clk3_is", 32'(is_sprite), 32'd1);
      step(0, 500, 300, 100, 50, 0, 0);
      check("lat_clk4_rgb", 32'(sprite_rgb), 32'(KEY));

      // Looping action 1.
      step(0, 0, 0, 100, 50, 1, 1);
      step(1, 100, 50, 100, 50, 1, 1);
      for (int i = 0; i < 5; i++) begin
         step(1, 100, 50, 100, 50, 1, 1);
         step(0, 100, 50, 100, 50, 1, 1);
         check($sformatf("loop_tick%0d_addr", i), 32'(rom_addr),
               32'((1 * N_FRM + frm_loop[i]) * FRM_SZ));
      end

      // One-shot action 3 holds its last frame and raises anim_done.
      step(0, 0, 0, 100, 50, 1, 3);
      for (int i = 0; i < 5; i++) begin
         step(1, 100, 50, 100, 50, 1, 3);
         check($sformatf("shot_tick%0d_done", i), 32'(anim_done), 32'(done_shot[i]));
         step(0, 100, 50, 100, 50, 1, 3);
         check($sformatf("shot_tick%0d_addr", i), 32'(rom_addr),
               32'((3 * N_FRM + frm_shot[i]) * FRM_SZ));
      end

      // Mid-frame position change is ignored until the frame-start latch.
      step(0, 101, 51, 300, 50, 1, 3);
      check("tear_old_pos", 32'(rom_addr), 32'd10727);
      step(0, 0, 0, 300, 50, 1, 3);
      step(0, 301, 51, 300, 50, 1, 3);
      check("tear_new_pos", 32'(rom_addr), 32'd10727);
      step(0, 101, 51, 300, 50, 1, 3);
      check("tear_old_gone", 32'(rom_addr), 32'd0);

      // Asynchronous reset in the middle of a drawn line.
      step(0, 300, 60, 300, 50, 1, 3);
      step(0, 301, 60, 300, 50, 1, 3);
      #2 rst = 1'b1;
      #1;
      check("arst_is_sprite", 32'(is_sprite), 32'd0);
      check("arst_rgb", 32'(sprite_rgb), 32'(KEY));
      check("arst_anim_done", 32'(anim_done), 32'd0);
      check("arst_addr", 32'(rom_addr), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 4; i++) step(0, 300, 60, 300, 50, 1, 3);
      check("post_rst_no_draw", 32'(is_sprite), 32'd0);
      check("post_rst_frame0", 32'(rom_addr), 32'd0);
      step(0, 0, 0, 300, 50, 1, 0);

      // Randomized traffic, including clipped and wrapped positions.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 39) == 0) begin
            case ($urandom_range(0, 3))
               0:       px = int'($urandom_range(0, 1023));
               1:       px = 1023;
               2:       px = 640 - SPR_W + 5;
               default: px = int'($urandom_range(0, 600));
            endcase
            py = ($urandom_range(0, 3) == 0) ? 1023 : int'($urandom_range(0, 479));
            step($urandom_range(0, 5) == 0, 0, 0, px, py, 1'($urandom),
                 int'($urandom_range(0, 3)));
         end else begin
            c = (m_px + int'($urandom_range(0, 40)) - 4) & 1023;
            r = (m_py + int'($urandom_range(0, 28)) - 3) & 1023;
            step($urandom_range(0, 5) == 0, c, r, int'($urandom_range(0, 1023)),
                 int'($urandom_range(0, 1023)), 1'($urandom), int'($urandom_range(0, 3)));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
